// File: rtl/game_end_controller.sv
// End-of-game controller: latches the first player time-out, reports the
// loser and any draw, then plays a timed buzzer pattern that ACK can cut short.
module game_end_controller #(
    parameter  int N_PLAYERS  = 2,
    parameter  int BEEP_ON    = 250,
    parameter  int BEEP_OFF   = 250,
    parameter  int BEEP_COUNT = 3,
    localparam int IDX_W      = $clog2(N_PLAYERS)
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 CE,
    input  logic [N_PLAYERS-1:0] OVERFLOW,
    input  logic                 ACK,
    output logic                 END,
    output logic [IDX_W-1:0]     LOSER,
    output logic                 DRAW,
    output logic                 BEEP
);

    // Counter sizing: tick spans the longer phase, pulse spans the alarm pulses.
    localparam int TICK_MAX  = ((BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF) - 1;
    localparam int TICK_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int PULSE_MAX = ((BEEP_COUNT - 1) > 1) ? (BEEP_COUNT - 1) : 1;
    localparam int PULSE_W   = $clog2(PULSE_MAX + 1);

    localparam logic [TICK_W-1:0]  ON_LAST    = TICK_W'(BEEP_ON - 1);
    localparam logic [TICK_W-1:0]  OFF_LAST   = TICK_W'(BEEP_OFF - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'((BEEP_COUNT > 0) ? (BEEP_COUNT - 1) : 0);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ALARM,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 end_q, end_d;
    logic [IDX_W-1:0]     loser_q, loser_d;
    logic                 draw_q, draw_d;
    logic                 beep_q, beep_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;

    logic [IDX_W-1:0]     low_idx;
    logic                 multi_set;
    int                   n_set;

    // Lowest flagged player and whether more than one flagged together.
    always_comb begin
        low_idx = '0;
        n_set   = 0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (OVERFLOW[i]) begin
                low_idx = IDX_W'(i);
                n_set   = n_set + 1;
            end
        end
        multi_set = (n_set > 1);
    end

    // State and output registers; CLR returns everything to idle at once.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_RUN;
            end_q   <= 1'b0;
            loser_q <= '0;
            draw_q  <= 1'b0;
            beep_q  <= 1'b0;
            tick_q  <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            end_q   <= end_d;
            loser_q <= loser_d;
            draw_q  <= draw_d;
            beep_q  <= beep_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state: capture in RUN, ON/OFF pulse sequencing in ALARM, hold in DONE.
    always_comb begin
        state_d = state_q;
        end_d   = end_q;
        loser_d = loser_q;
        draw_d  = draw_q;
        beep_d  = beep_q;
        tick_d  = tick_q;
        pulse_d = pulse_q;

        unique case (state_q)
            ST_RUN: begin
                if (CE && (OVERFLOW != '0)) begin
                    end_d   = 1'b1;
                    loser_d = low_idx;
                    draw_d  = multi_set;
                    tick_d  = '0;
                    pulse_d = '0;
                    if (BEEP_COUNT > 0) begin
                        state_d = ST_ALARM;
                        beep_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ALARM: begin
                // ACK is not gated by CE and overrides a coincident tick.
                if (ACK) begin
                    beep_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (CE) begin
                    if (beep_q) begin
                        if (tick_q == ON_LAST) begin
                            beep_d = 1'b0;
                            tick_d = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end else begin
                        if (tick_q == OFF_LAST) begin
                            tick_d = '0;
                            if (pulse_q == PULSE_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                pulse_d = pulse_q + PULSE_W'(1);
                                beep_d  = 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                beep_d = 1'b0;
            end
            default: begin
                state_d = ST_DONE;
                beep_d  = 1'b0;
            end
        endcase
    end

    assign END   = end_q;
    assign LOSER = loser_q;
    assign DRAW  = draw_q;
    assign BEEP  = beep_q;

endmodule

// File: tb/tb_game_end_controller.sv
// Bench for game_end_controller: a 2-player alarm instance and a 4-player
// no-alarm instance, both compared each cycle against a tick-count model.
module tb_game_end_controller;

    localparam int ON    = 2;
    localparam int OFF   = 2;
    localparam int COUNT = 3;
    localparam int P     = ON + OFF;
    localparam int TOTAL = COUNT * P;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       ce  = 1'b0;
    logic       ack = 1'b0;
    logic [1:0] ovf = '0;
    logic [3:0] ovf4 = '0;

    logic       end2, draw2, beep2;
    logic [0:0] loser2;
    logic       end4, draw4, beep4;
    logic [1:0] loser4;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: capture info, CE ticks counted since capture, ACK seen.
    logic       m_end, m_draw, m_ack;
    int         m_loser, m_k;
    logic       m4_end, m4_draw;
    int         m4_loser;

    game_end_controller #(.N_PLAYERS(2), .BEEP_ON(ON), .BEEP_OFF(OFF), .BEEP_COUNT(COUNT)) dut2 (
        .CLK(CLK), .CLR(CLR), .CE(ce), .OVERFLOW(ovf), .ACK(ack),
        .END(end2), .LOSER(loser2), .DRAW(draw2), .BEEP(beep2)
    );

    game_end_controller #(.N_PLAYERS(4), .BEEP_ON(ON), .BEEP_OFF(OFF), .BEEP_COUNT(0)) dut4 (
        .CLK(CLK), .CLR(CLR), .CE(ce), .OVERFLOW(ovf4), .ACK(ack),
        .END(end4), .LOSER(loser4), .DRAW(draw4), .BEEP(beep4)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic exp_beep();
        return m_end && !m_ack && (m_k < TOTAL) && ((m_k % P) < ON);
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".end2"},   32'(end2),   32'(m_end));
        check({ctx, ".loser2"}, 32'(loser2), 32'(m_loser));
        check({ctx, ".draw2"},  32'(draw2),  32'(m_draw));
        check({ctx, ".beep2"},  32'(beep2),  32'(exp_beep()));
        check({ctx, ".end4"},   32'(end4),   32'(m4_end));
        check({ctx, ".loser4"}, 32'(loser4), 32'(m4_loser));
        check({ctx, ".draw4"},  32'(draw4),  32'(m4_draw));
        check({ctx, ".beep4"},  32'(beep4),  32'd0);
    endtask

    task automatic model_clear();
        m_end = 0; m_draw = 0; m_ack = 0; m_loser = 0; m_k = 0;
        m4_end = 0; m4_draw = 0; m4_loser = 0;
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic cyc(input string ctx);
        @(posedge CLK);
        if (!m_end) begin
            if (ce && ovf != '0) begin
                m_end = 1; m_loser = lowest({2'b00, ovf});
                m_draw = ($countones(ovf) > 1); m_k = 0; m_ack = 0;
            end
        end else if (!m_ack && m_k < TOTAL) begin
            if (ack) m_ack = 1;
            else if (ce) m_k++;
        end
        if (!m4_end && ce && ovf4 != '0) begin
            m4_end = 1; m4_loser = lowest(ovf4); m4_draw = ($countones(ovf4) > 1);
        end
        #1;
        check_all(ctx);
    endtask

    // Asynchronous clear mid-cycle: outputs must drop before any clock edge.
    task automatic do_reset(input string ctx);
        #2;
        CLR = 1'b1;
        #1;
        model_clear();
        check_all({ctx, ".clr"});
        @(negedge CLK);
        CLR = 1'b0;
        ce = 0; ack = 0; ovf = '0; ovf4 = '0;
    endtask

    initial begin
        model_clear();
        #1;
        check_all("por");
        @(negedge CLK);
        CLR = 1'b0;

        // Capture of player 1; ACK in RUN beforehand has no effect.
        ce = 1; ack = 1;
        cyc("t1_ackrun");
        ack = 0; ovf = 2'b10; ovf4 = 4'b1100;
        cyc("t1_cap");
        check("t1_loser_const", 32'(loser2), 32'd1);
        check("t1_beep_first", 32'(beep2), 32'd1);
        check("t4_loser_const", 32'(loser4), 32'd2);
        check("t4_draw_const", 32'(draw4), 32'd1);
        ovf = '0; ovf4 = '0;
        for (int i = 0; i < 16; i++) cyc("t1_alarm");
        check("t1_end_held", 32'(end2), 32'd1);

        // Simultaneous flags produce a draw; later flags are ignored.
        do_reset("t2");
        ce = 1; ovf = 2'b11;
        cyc("t2_cap");
        check("t2_draw_const", 32'(draw2), 32'd1);
        ovf = '0;
        for (int i = 0; i < 3; i++) cyc("t2_wait");
        ovf = 2'b10; ovf4 = 4'b0010;
        for (int i = 0; i < 12; i++) cyc("t2_late");
        check("t2_loser_const", 32'(loser2), 32'd0);
        ovf = '0; ovf4 = '0;

        // Flag without CE is ignored; alarm then advances on 1-of-4 CE cycles.
        do_reset("t3");
        ce = 0; ovf = 2'b01;
        for (int i = 0; i < 3; i++) cyc("t3_noce");
        check("t3_end_noce", 32'(end2), 32'd0);
        ce = 1;
        cyc("t3_cap");
        ovf = '0;
        for (int i = 1; i <= 56; i++) begin
            ce = ((i % 4) == 0);
            cyc("t3_slow");
        end

        // ACK in the second ON phase with a coincident CE tick.
        do_reset("t5");
        ce = 1; ovf = 2'b01;
        cyc("t5_cap");
        ovf = '0;
        for (int i = 0; i < 4; i++) cyc("t5_run");
        ack = 1;
        cyc("t5_ack");
        check("t5_beep_off", 32'(beep2), 32'd0);
        ack = 0;
        for (int i = 0; i < 8; i++) cyc("t5_done");

        // Clear during an OFF phase, then a fresh full alarm.
        do_reset("t6a");
        ce = 1; ovf = 2'b10;
        cyc("t6_cap");
        ovf = '0;
        for (int i = 0; i < 6; i++) cyc("t6_run");
        check("t6_in_off", 32'(beep2), 32'd0);
        do_reset("t6");
        check("t6_beep_async", 32'(beep2), 32'd0);
        check("t6_end_async", 32'(end2), 32'd0);
        ce = 1; ovf = 2'b01;
        cyc("t6_recap");
        ovf = '0;
        for (int i = 0; i < TOTAL + 4; i++) cyc("t6_full");

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset("rnd");
            for (int i = 0; i < 50; i++) begin
                ce   = ($urandom % 4) != 0;
                ovf  = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
                ovf4 = (($urandom % 8) == 0) ? 4'($urandom) : 4'b0000;
                ack  = ($urandom % 20) == 0;
                cyc("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
